// File: rtl/misr_compactor_if.sv
// ---------------------------------------------------------------------------
// misr_compactor_if
// Bundles the run-control, data and status signals between a BIST controller
// and the MISR compactor.
//   master : BIST controller side (drives start/enable/data/config, reads status)
//   slave  : compactor side
// Signals:
//   MISR_Start   single-cycle start pulse
//   MISR_En      scan-out slice valid this cycle
//   MISR_In      scan-chain outputs, one bit per chain
//   MISR_Mask    per-chain X mask (only when MISR_XMASK_EN is defined)
//   MISR_Poly    feedback polynomial (top bit unused)
//   MISR_Seed    initial signature, captured at start
//   MISR_Len     number of enabled cycles to compact
//   MISR_Golden  expected signature
//   MISR_Sig     current signature
//   MISR_Cnt     enabled cycles compacted so far
//   MISR_Busy    run in progress (compacting or comparing)
//   MISR_Done    run finished, MISR_Pass valid
//   MISR_Pass    signature matched golden
// Optional feature macro: MISR_XMASK_EN
// ---------------------------------------------------------------------------
interface misr_compactor_if #(
   parameter int MISR_Size = 32,
   parameter int CNT_W     = 16
);
   logic                 MISR_Start;
   logic                 MISR_En;
   logic [MISR_Size-1:0] MISR_In;
`ifdef MISR_XMASK_EN
   logic [MISR_Size-1:0] MISR_Mask;
`endif
   logic [MISR_Size-1:0] MISR_Poly;
   logic [MISR_Size-1:0] MISR_Seed;
   logic [CNT_W-1:0]     MISR_Len;
   logic [MISR_Size-1:0] MISR_Golden;
   logic [MISR_Size-1:0] MISR_Sig;
   logic [CNT_W-1:0]     MISR_Cnt;
   logic                 MISR_Busy;
   logic                 MISR_Done;
   logic                 MISR_Pass;

   modport master (
      output MISR_Start,
      output MISR_En,
      output MISR_In,
`ifdef MISR_XMASK_EN
      output MISR_Mask,
`endif
      output MISR_Poly,
      output MISR_Seed,
      output MISR_Len,
      output MISR_Golden,
      input  MISR_Sig,
      input  MISR_Cnt,
      input  MISR_Busy,
      input  MISR_Done,
      input  MISR_Pass
   );

   modport slave (
      input  MISR_Start,
      input  MISR_En,
      input  MISR_In,
`ifdef MISR_XMASK_EN
      input  MISR_Mask,
`endif
      input  MISR_Poly,
      input  MISR_Seed,
      input  MISR_Len,
      input  MISR_Golden,
      output MISR_Sig,
      output MISR_Cnt,
      output MISR_Busy,
      output MISR_Done,
      output MISR_Pass
   );
endinterface

// File: rtl/misr_compactor.sv
// ---------------------------------------------------------------------------
// misr_compactor
// Multiple-input signature register with run controller at the scan-out end
// of the STUMPS BIST datapath. After a start pulse it compacts MISR_Len
// enabled slices, compares the signature with MISR_Golden for one cycle and
// then reports done/pass until the next start.
// Shift orientation matches the PRPG: right shift, feedback from bit 0.
//
// Ports:
//   clk          clock, rising edge
//   internalRst  asynchronous, active-high reset
//   bus          misr_compactor_if.slave (control, data, config, status)
//
// Optional feature macro: MISR_XMASK_EN -- when defined, chains whose
// MISR_Mask bit is set contribute 0 to the compaction step.
//
// State table:
//   state       | meaning
//   ST_IDLE     | waiting for start after reset
//   ST_COMPACT  | folding one slice into the signature per enabled cycle
//   ST_COMPARE  | one cycle: latch signature == golden into pass
//   ST_DONE     | result held; start re-runs with a fresh seed
// ---------------------------------------------------------------------------
module misr_compactor #(
   parameter int MISR_Size = 32,
   parameter int CNT_W     = 16
) (
   input logic              clk,
   input logic              internalRst,
   misr_compactor_if.slave  bus
);

   localparam int MSB = MISR_Size - 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPACT = 2'd1,
      ST_COMPARE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [MISR_Size-1:0] sig;
   logic [MISR_Size-1:0] sig_step;
   logic [MISR_Size-1:0] din;
   logic [CNT_W-1:0]     cnt;
   logic                 pass;
   logic                 load_seed;
   logic                 do_step;
   logic                 do_cmp;
   logic                 last_step;

   // The top polynomial bit has no tap: bit MSB is fed from bit 0 directly.
   logic unused_poly_msb;
   assign unused_poly_msb = bus.MISR_Poly[MSB];

`ifdef MISR_XMASK_EN
   assign din = bus.MISR_In & ~bus.MISR_Mask;
`else
   assign din = bus.MISR_In;
`endif

   always_comb begin
      sig_step      = '0;
      sig_step[MSB] = sig[0] ^ din[MSB];
      for (int i = 0; i < MSB; i++) begin
         sig_step[i] = (sig[0] & bus.MISR_Poly[i]) ^ sig[i+1] ^ din[i];
      end
   end

   // Len=0 never reaches COMPACT, so Len-1 cannot underflow in use.
   assign last_step = (cnt == (bus.MISR_Len - CNT_W'(1)));

   always_ff @(posedge clk or posedge internalRst) begin
      if (internalRst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_seed = 1'b0;
      do_step   = 1'b0;
      do_cmp    = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.MISR_Start) begin
               load_seed = 1'b1;
               state_nxt = (bus.MISR_Len == '0) ? ST_COMPARE : ST_COMPACT;
            end
         end
         ST_COMPACT: begin
            if (bus.MISR_En) begin
               do_step = 1'b1;
               if (last_step) begin
                  state_nxt = ST_COMPARE;
               end
            end
         end
         ST_COMPARE: begin
            do_cmp    = 1'b1;
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge internalRst) begin
      if (internalRst) begin
         sig  <= '0;
         cnt  <= '0;
         pass <= 1'b0;
      end else begin
         if (load_seed) begin
            sig  <= bus.MISR_Seed;
            cnt  <= '0;
            pass <= 1'b0;
         end else if (do_step) begin
            sig <= sig_step;
            cnt <= cnt + CNT_W'(1);
         end
         if (do_cmp) begin
            pass <= (sig == bus.MISR_Golden);
         end
      end
   end

   assign bus.MISR_Sig  = sig;
   assign bus.MISR_Cnt  = cnt;
   assign bus.MISR_Busy = (state == ST_COMPACT) || (state == ST_COMPARE);
   assign bus.MISR_Done = (state == ST_DONE);
   assign bus.MISR_Pass = pass;

endmodule

// File: doc/misr_compactor.md
Name: misr_compactor

Overview:
- Multiple-input signature register (MISR) with a run controller, placed at the scan-out end of the STUMPS BIST datapath.
- Compacts one PRPG_Size-wide slice of scan-chain outputs per enabled cycle for a programmed number of cycles.
- Then compares the final signature against a golden value and reports pass/fail to the BIST controller.
- Uses the same polynomial and shift orientation as the PRPG: right shift, feedback taken from bit 0.

Parameters:
- MISR_Size, 32, signature and input width in bits.
- CNT_W, 16, width of the compaction-cycle counter and the length input.

Ports:
- clk  input  1  clock, rising edge.
- internalRst  input  1  asynchronous, active-high reset.
- MISR_Start  input  1  single-cycle start pulse; honoured only in IDLE or DONE.
- MISR_En  input  1  scan-out slice valid this cycle.
- MISR_In  input  MISR_Size  scan-chain outputs, one bit per chain.
- MISR_Poly  input  MISR_Size  feedback polynomial; bit MISR_Size-1 is unused.
- MISR_Seed  input  MISR_Size  initial signature, loaded on start.
- MISR_Len  input  CNT_W  number of enabled cycles to compact.
- MISR_Golden  input  MISR_Size  expected signature.
- MISR_Sig  output  MISR_Size  current signature register.
- MISR_Cnt  output  CNT_W  enabled cycles compacted so far in this run.
- MISR_Busy  output  1  high in COMPACT and COMPARE.
- MISR_Done  output  1  high in DONE.
- MISR_Pass  output  1  compare result; valid while MISR_Done=1.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, MISR_Sig=0, MISR_Cnt=0, MISR_Busy=0, MISR_Done=0, MISR_Pass=0.
- Compaction step, applied when state=COMPACT and MISR_En=1:
  - Sig[MSB] <= Sig[0] ^ In[MSB].
  - For i < MSB: Sig[i] <= (Sig[0] & Poly[i]) ^ Sig[i+1] ^ In[i].
  - MISR_Cnt increments by 1.
- With MISR_En=0 in COMPACT, Sig and Cnt hold.
- Inputs MISR_Poly, MISR_Golden and MISR_Len must stay stable from start until DONE. The block does not capture them, except that MISR_Seed is captured at start.
- IDLE:
  - MISR_Start=1: Sig <= Seed, Cnt <= 0, Pass <= 0.
  - Next state is COMPACT, or COMPARE directly when MISR_Len=0.
- COMPACT: on an enabled cycle with Cnt == Len-1, perform that final step, then go to COMPARE next cycle.
- COMPARE (exactly 1 cycle): Pass <= (Sig == Golden); go to DONE.
- DONE:
  - Done=1; Sig, Cnt and Pass hold.
  - MISR_Start=1 restarts exactly as from IDLE (seed reload), with Done dropping the next cycle.
- Timing: Done rises 2 cycles after the final enabled COMPACT cycle edge, i.e. Len + 2 clocks after start with En held high.
- MISR_Start during COMPACT or COMPARE is ignored. MISR_Start and MISR_En asserted in the same IDLE cycle: only the seed load occurs, with no compaction.
- Counter arithmetic is unsigned modulo 2^CNT_W. Len=2^CNT_W-1 is the maximum run; the counter never wraps within a run.
- Asserting internalRst mid-run aborts immediately to the reset values.

Optional Feature:
- Macro MISR_XMASK_EN.
- When defined:
  - Adds input port MISR_Mask [MISR_Size-1:0], placed after MISR_In.
  - The compaction step uses (MISR_In & ~MISR_Mask), so masked chains (unknown-value X sources) contribute 0.
  - Counting and FSM behaviour are unchanged.
- When undefined: the port does not exist and MISR_In is used unmasked.

Test Plan:
- MISR_Size=4. Seed=4'b0001, Poly=4'b0011, In=0, Len=1, En=1 -> Sig=4'b1011, Cnt=1, Done high 3 clocks after start. Golden=4'b1011 -> Pass=1.
- MISR_Size=4. Seed=0, Len=1, In=4'hA -> Sig=4'hA. Golden=4'hB -> Done=1, Pass=0.
- Len=3 with En pattern 1,0,1,0,1 -> Cnt goes 1,1,2,2,3; COMPARE follows the 5th enabled-window cycle; disabled cycles leave Sig unchanged.
- Len=0, Seed=Golden=32'hDEADBEEF, start -> no compaction; Done after 2 clocks; Pass=1.
- Assert internalRst mid-COMPACT -> Sig=0, Cnt=0, Busy=0, state IDLE; a start in the same cycle is ignored. Start pulse while Busy -> no effect, and the run completes normally.
- MISR_XMASK_EN defined, MISR_Size=4, Seed=0, Len=1, In=4'hF, Mask=4'h5 -> Sig=4'hA.
